// File: rtl/zero_detection_if.sv
// Operand/flag bundle for the zero_detection operand-gating detector.
// master drives operands and threshold; slave returns the registered flags.
interface zero_detection_if #(
  parameter int unsigned WIDTH_A = 16,
  parameter int unsigned WIDTH_B = 16,
  parameter int unsigned WIDTH_T = 2,
  parameter int unsigned CNT_W   = 16
);
  logic               in_valid;
  logic [WIDTH_A-1:0] A;
  logic [WIDTH_B-1:0] B;
  logic [WIDTH_T-1:0] Thres;
  logic               out_valid;
  logic               Zero;
  logic               zero_a;
  logic               zero_b;
  logic [CNT_W-1:0]   skip_cnt;

  modport master (
    output in_valid, A, B, Thres,
    input  out_valid, Zero, zero_a, zero_b, skip_cnt
  );

  modport slave (
    input  in_valid, A, B, Thres,
    output out_valid, Zero, zero_a, zero_b, skip_cnt
  );
endinterface

// File: rtl/zero_detection.sv
// Registered exact/near-zero operand detector with saturating skip counter.
// Define ZERO_DET_NEAR_EN to compile in the exponent-below-threshold test.
module zero_detection #(
  parameter int unsigned WIDTH_A = 16,
  parameter int unsigned WIDTH_B = 16,
  parameter int unsigned WIDTH_T = 2,
  parameter int unsigned EXP_W   = 5,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  zero_detection_if.slave  bus
);

  logic             exact_a_c;
  logic             exact_b_c;
  logic             near_a_c;
  logic             near_b_c;
  logic             zero_a_c;
  logic             zero_b_c;
  logic [EXP_W-1:0] exp_a_c;
  logic [EXP_W-1:0] exp_b_c;

  logic             out_valid_d, out_valid_q;
  logic             zero_a_d,    zero_a_q;
  logic             zero_b_d,    zero_b_q;
  logic             zero_d,      zero_q;
  logic [CNT_W-1:0] skip_cnt_d,  skip_cnt_q;

  // Per-operand classification; sign bit never participates.
  always_comb begin
    exp_a_c   = bus.A[WIDTH_A-2 -: EXP_W];
    exp_b_c   = bus.B[WIDTH_B-2 -: EXP_W];
    exact_a_c = ~|bus.A[WIDTH_A-2:0];
    exact_b_c = ~|bus.B[WIDTH_B-2:0];
`ifdef ZERO_DET_NEAR_EN
    near_a_c  = exp_a_c < EXP_W'(bus.Thres);
    near_b_c  = exp_b_c < EXP_W'(bus.Thres);
`else
    near_a_c  = 1'b0;
    near_b_c  = 1'b0;
`endif
    zero_a_c  = exact_a_c | near_a_c;
    zero_b_c  = exact_b_c | near_b_c;
  end

`ifdef ZERO_DET_NEAR_EN
  logic unused_c;
  assign unused_c = &{1'b0, bus.A[WIDTH_A-1], bus.B[WIDTH_B-1]};
`else
  logic unused_c;
  assign unused_c = &{1'b0, bus.A[WIDTH_A-1], bus.B[WIDTH_B-1],
                      bus.Thres, exp_a_c, exp_b_c};
`endif

  // Flags clear on idle cycles; counter saturates instead of wrapping.
  always_comb begin
    out_valid_d = bus.in_valid;
    zero_a_d    = 1'b0;
    zero_b_d    = 1'b0;
    zero_d      = 1'b0;
    skip_cnt_d  = skip_cnt_q;
    if (bus.in_valid) begin
      zero_a_d = zero_a_c;
      zero_b_d = zero_b_c;
      zero_d   = zero_a_c | zero_b_c;
      if ((zero_a_c | zero_b_c) && (skip_cnt_q != {CNT_W{1'b1}})) begin
        skip_cnt_d = skip_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      zero_a_q    <= 1'b0;
      zero_b_q    <= 1'b0;
      zero_q      <= 1'b0;
      skip_cnt_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      zero_a_q    <= zero_a_d;
      zero_b_q    <= zero_b_d;
      zero_q      <= zero_d;
      skip_cnt_q  <= skip_cnt_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.zero_a    = zero_a_q;
  assign bus.zero_b    = zero_b_q;
  assign bus.Zero      = zero_q;
  assign bus.skip_cnt  = skip_cnt_q;

endmodule

// File: tb/tb_zero_detection.sv
// Bench for zero_detection: directed table, corner sequences, random vs model.
// Narrow skip counter so saturation is reachable in a short run.
module tb_zero_detection;

  localparam int unsigned CNT_W   = 4;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  logic clk;
  logic rst_n;

  zero_detection_if #(.WIDTH_A(16), .WIDTH_B(16), .WIDTH_T(2), .CNT_W(CNT_W)) bus ();

  zero_detection #(
    .WIDTH_A(16), .WIDTH_B(16), .WIDTH_T(2), .EXP_W(5), .CNT_W(CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  t;
    logic [2:0]  near;   // {zero_a, zero_b, Zero} with near-zero test compiled in
    logic [2:0]  exact;  // {zero_a, zero_b, Zero} with exact-zero only
    string       name;
  } vec_t;

  vec_t vecs[$];

  int n_checks = 0;
  int n_fail   = 0;

  logic m_ov, m_za, m_zb;
  int   m_cnt;

  // FP16 reference: magnitude zero, or exponent below threshold when enabled.
  function automatic logic is_zero(input logic [15:0] x, input int t);
    int e   = (int'(x) / 1024) % 32;
    int mag = int'(x) % 32768;
    if (mag == 0) return 1'b1;
`ifdef ZERO_DET_NEAR_EN
    if (e < t) return 1'b1;
`else
    if (t < 0 && e < 0) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic logic [15:0] rnd_op();
    logic [15:0] x = 16'($urandom);
    case ($urandom_range(3, 0))
      0: x[14:10] = 5'($urandom_range(3, 0));
      1: x[14:0]  = '0;
      default: ;
    endcase
    return x;
  endfunction

  function automatic void add_vec(input logic [15:0] a, input logic [15:0] b, input logic [1:0] t,
                                  input logic [2:0] near, input logic [2:0] exact, input string name);
    vec_t v;
    v.a = a; v.b = b; v.t = t; v.near = near; v.exact = exact; v.name = name;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle, advance the model, check all outputs just after the edge.
  task automatic step(input logic r, input logic v, input logic [15:0] a, input logic [15:0] b,
                      input logic [1:0] t, input string tag);
    @(negedge clk);
    rst_n        = r;
    bus.in_valid = v;
    bus.A        = a;
    bus.B        = b;
    bus.Thres    = t;
    if (!r) begin
      m_ov = 1'b0; m_za = 1'b0; m_zb = 1'b0; m_cnt = 0;
    end else if (v) begin
      m_ov = 1'b1;
      m_za = is_zero(a, int'(t));
      m_zb = is_zero(b, int'(t));
      if ((m_za || m_zb) && m_cnt < CNT_MAX) m_cnt++;
    end else begin
      m_ov = 1'b0; m_za = 1'b0; m_zb = 1'b0;
    end
    @(posedge clk);
    #1;
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(m_ov));
    chk({tag, ".zero_a"},    32'(bus.zero_a),    32'(m_za));
    chk({tag, ".zero_b"},    32'(bus.zero_b),    32'(m_zb));
    chk({tag, ".Zero"},      32'(bus.Zero),      32'(m_za | m_zb));
    chk({tag, ".skip_cnt"},  32'(bus.skip_cnt),  32'(m_cnt));
  endtask

  initial begin
    logic [2:0] e3;
    int         cnt_before;

    rst_n = 1'b0; bus.in_valid = 1'b0; bus.A = '0; bus.B = '0; bus.Thres = '0;
    m_ov = 1'b0; m_za = 1'b0; m_zb = 1'b0; m_cnt = 0;

    add_vec(16'h0000, 16'h3C00, 2'd1, 3'b101, 3'b101, "exact_a");
    add_vec(16'h3C00, 16'h0000, 2'd1, 3'b011, 3'b011, "exact_b");
    add_vec(16'h8000, 16'h3C00, 2'd0, 3'b101, 3'b101, "neg_zero_a");
    add_vec(16'h0400, 16'h07FF, 2'd1, 3'b000, 3'b000, "exp1_t1");
    add_vec(16'h0400, 16'h07FF, 2'd2, 3'b111, 3'b000, "exp1_t2");
    add_vec(16'h3C00, 16'h3C00, 2'd1, 3'b000, 3'b000, "big_t1");
    add_vec(16'h3C00, 16'h3C00, 2'd3, 3'b000, 3'b000, "big_t3");
    add_vec(16'h0001, 16'h0001, 2'd1, 3'b111, 3'b000, "denorm_t1");
    add_vec(16'h0001, 16'h8001, 2'd0, 3'b000, 3'b000, "denorm_t0");
    add_vec(16'h0800, 16'h0800, 2'd2, 3'b000, 3'b000, "sweep_t2");
    add_vec(16'h0800, 16'h0800, 2'd3, 3'b111, 3'b000, "sweep_t3");
    add_vec(16'h0800, 16'h0800, 2'd0, 3'b000, 3'b000, "sweep_t0");
    add_vec(16'h0800, 16'h0800, 2'd1, 3'b000, 3'b000, "sweep_t1");
    add_vec(16'hFC00, 16'h8000, 2'd3, 3'b011, 3'b011, "neg_big_a");

    step(1'b0, 1'b1, 16'h0000, 16'h0000, 2'd1, "reset0");
    step(1'b0, 1'b0, 16'h0000, 16'h0000, 2'd0, "reset1");

    for (int i = 0; i < vecs.size(); i++) begin
      step(1'b1, 1'b1, vecs[i].a, vecs[i].b, vecs[i].t, vecs[i].name);
`ifdef ZERO_DET_NEAR_EN
      e3 = vecs[i].near;
`else
      e3 = vecs[i].exact;
`endif
      chk({vecs[i].name, ".tbl_zero_a"}, 32'(bus.zero_a), 32'(e3[2]));
      chk({vecs[i].name, ".tbl_zero_b"}, 32'(bus.zero_b), 32'(e3[1]));
      chk({vecs[i].name, ".tbl_Zero"},   32'(bus.Zero),   32'(e3[0]));
    end

    // Sweep: only the Thres=3 cycle (near build) bumps the counter.
    cnt_before = int'(bus.skip_cnt);
    step(1'b1, 1'b1, 16'h0800, 16'h0800, 2'd2, "sw2");
    chk("sw2.cnt_hold", 32'(bus.skip_cnt), 32'(cnt_before));
    step(1'b1, 1'b1, 16'h0800, 16'h0800, 2'd3, "sw3");
`ifdef ZERO_DET_NEAR_EN
    chk("sw3.cnt_inc", 32'(bus.skip_cnt), 32'(cnt_before + 1));
`else
    chk("sw3.cnt_hold", 32'(bus.skip_cnt), 32'(cnt_before));
`endif

    // Reset beats a valid zero pair mid-stream.
    step(1'b0, 1'b1, 16'h0000, 16'h0000, 2'd1, "rst_mid");
    chk("rst_mid.cnt_zero", 32'(bus.skip_cnt), 32'd0);
    step(1'b1, 1'b1, 16'h0000, 16'h3C00, 2'd0, "post_rst");
    step(1'b1, 1'b0, 16'h0000, 16'h0000, 2'd1, "idle_zero");
    chk("idle_zero.Zero", 32'(bus.Zero), 32'd0);
    chk("idle_zero.cnt",  32'(bus.skip_cnt), 32'd1);

    // Saturation: many exact-zero pairs pin the counter at its maximum.
    for (int i = 0; i < CNT_MAX + 3; i++) step(1'b1, 1'b1, 16'h0000, 16'h0000, 2'd0, "sat");
    chk("sat.max", 32'(bus.skip_cnt), 32'(CNT_MAX));
    step(1'b1, 1'b1, 16'h8000, 16'h0000, 2'd0, "sat_more");
    chk("sat_more.max", 32'(bus.skip_cnt), 32'(CNT_MAX));

    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(31, 0) != 0), ($urandom_range(3, 0) != 0),
           rnd_op(), rnd_op(), 2'($urandom_range(3, 0)), "rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
